// File: rtl/seq_mult32_ctrl_pkg.sv
// Shared ALU definitions for the sequential shift-add multiplier controller:
// default operand width, FSM state encoding and counter sizing helper.
package seq_mult32_ctrl_pkg;

  localparam int unsigned MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mult_state_e;

  // Iteration counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_mult32_cnt.sv
// Iteration counter for the multiplier: synchronous clear, count enable and
// a terminal-count flag raised on the last iteration.
module seq_mult32_cnt
  import seq_mult32_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/seq_mult32_ctrl.sv
// Sequential unsigned shift-add multiplier controller. Drives a shared external
// adder once per iteration and produces a 2*WIDTH product after WIDTH cycles.
module seq_mult32_ctrl
  import seq_mult32_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  mult_state_e       state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_tc_c;

  seq_mult32_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc_c (cnt_tc_c)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load = start;
      end
      ST_CALC: begin
        if (abort) begin
          state_d = ST_IDLE;
          hi_d    = '0;
          lo_d    = '0;
          m_d     = '0;
          cnt_clr = 1'b1;
        end else begin
          // Shift the adder result (with carry) down into {HI,LO}.
          hi_d = {add_cout, add_sum[WIDTH-1:1]};
          lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
          if (cnt_tc_c) begin
            state_d = ST_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d = ST_CALC;
      hi_d    = '0;
      lo_d    = mplier;
      m_d     = mcand;
      cnt_clr = 1'b1;
    end

    // Adder operands are staged so they line up with HI/LO/M in each CALC cycle.
    busy_d  = (state_d == ST_CALC);
    done_d  = (state_d == ST_DONE);
    add_a_d = busy_d ? hi_d : '0;
    add_b_d = (busy_d && lo_d[0]) ? m_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = 1'b0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_mult32_ctrl.sv
// Self-checking bench for seq_mult32_ctrl: external adder model, arithmetic
// reference model, directed corner scenarios and randomized traffic.
module tb_seq_mult32_ctrl;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int failures = 0;

  // Reference model: k = 0 idle/held, 1..W in calculation, W+1 done pulse.
  int             k = 0;
  logic [63:0]    res = '0;
  logic [W-1:0]   ma = '0;
  logic [W-1:0]   mb = '0;
  logic           cout_seen = 1'b0;

  seq_mult32_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mcand    (mcand),
    .mplier   (mplier),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  // External adder placed beside the controller.
  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {HI,LO} after i iterations: partial product in the top, unused multiplier bits below.
  function automatic logic [63:0] partial(input logic [W-1:0] a, input logic [W-1:0] b, input int i);
    logic [63:0] mask;
    logic [63:0] p;
    mask = (64'd1 << i) - 64'd1;
    p = 64'(a) * (64'(b) & mask);
    return (p << (W - i)) + (64'(b) >> i);
  endfunction

  task automatic model_edge();
    if (k >= 1 && k <= W) begin
      if (abort) begin
        k = 0;
        res = '0;
      end else begin
        k++;
        if (k == W + 1) res = 64'(ma) * 64'(mb);
      end
    end else if (start) begin
      k = 1;
      ma = mcand;
      mb = mplier;
    end else begin
      k = 0;
    end
  endtask

  task automatic compare();
    logic [63:0] e_prod;
    logic [W-1:0] e_a, e_b;
    logic e_busy, e_done;
    int i;
    if (k >= 1 && k <= W) begin
      i = k - 1;
      e_prod = partial(ma, mb, i);
      e_busy = 1'b1;
      e_done = 1'b0;
      e_a = e_prod[63:32];
      e_b = mb[i] ? ma : '0;
    end else begin
      e_prod = res;
      e_busy = 1'b0;
      e_done = (k == W + 1);
      e_a = '0;
      e_b = '0;
    end
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("product", product, e_prod);
    chk("add_a", 64'(add_a), 64'(e_a));
    chk("add_b", 64'(add_b), 64'(e_b));
    chk("add_cin", 64'(add_cin), 64'd0);
    if (busy && add_cout) cout_seen = 1'b1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_product"}, product, 64'd0);
    chk({tag, "_add_a"}, 64'(add_a), 64'd0);
    chk({tag, "_add_b"}, 64'(add_b), 64'd0);
    chk({tag, "_add_cin"}, 64'(add_cin), 64'd0);
  endtask

  // One operation; start is optionally re-pulsed in CALC cycle 'repulse'.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse,
                        input logic [63:0] exp_prod, input string tag);
    int cyc;
    int nbusy;
    mcand = a;
    mplier = b;
    start = 1'b1;
    step();
    chk({tag, "_busy_first"}, 64'(busy), 64'd1);
    start = 1'b0;
    cyc = 1;
    nbusy = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      if (cyc == repulse) begin
        start = 1'b1;
        mcand = $urandom;
        mplier = $urandom;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 64'(cyc), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd32);
    chk({tag, "_result"}, product, exp_prod);
  endtask

  initial begin
    int dseen;
    #1 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    run_op(32'd3, 32'd5, 0, 64'h0000_0000_0000_000F, "m3x5");
    step();
    step();

    cout_seen = 1'b0;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, "mffff");
    chk("mffff_cout_seen", 64'(cout_seen), 64'd1);
    step();

    run_op(32'd7, 32'd9, 10, 64'd63, "m7x9_repulse");
    step();

    run_op(32'd5, 32'd6, 0, 64'd30, "m5x6");
    run_op(32'd2, 32'd4, 0, 64'd8, "b2b_2x4");
    step();
    step();

    // Asynchronous reset in the middle of an operation.
    mcand = 32'd9;
    mplier = 32'd11;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    k = 0;
    res = '0;
    @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk) rst = 1'b0;
    step();
    run_op(32'd6, 32'd7, 0, 64'd42, "m6x7");
    step();

    // Abort together with start in CALC cycle 5.
    mcand = 32'd11;
    mplier = 32'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", product, 64'd0);
    dseen = 0;
    repeat (40) begin
      step();
      if (done) dseen++;
    end
    chk("abort_no_done", 64'(dseen), 64'd0);

    // Randomized traffic with occasional aborts and extreme operands.
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      mcand = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      case ($urandom_range(0, 3))
        0: mplier = '0;
        1: mplier = 32'hFFFF_FFFF;
        default: mplier = W'($urandom);
      endcase
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mult32_ctrl.md
SEQ_MULT32_CTRL -- requirements
Module: seq_mult32_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; the adder port width equals WIDTH.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE or DONE.
REQ-005 SHALL have port: abort  input  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port: mcand  input  WIDTH  multiplicand, captured when start is accepted.
REQ-007 SHALL have port: mplier  input  WIDTH  multiplier, captured when start is accepted.
REQ-008 SHALL have port: add_a  output  WIDTH  operand A to the shared external adder.
REQ-009 SHALL have port: add_b  output  WIDTH  operand B to the shared external adder.
REQ-010 SHALL have port: add_cin  output  1  adder carry-in, tied to 0.
REQ-011 SHALL have port: add_sum  input  WIDTH  adder sum, combinational return.
REQ-012 SHALL have port: add_cout  input  1  adder carry-out.
REQ-013 SHALL have port: busy  output  1  high in CALC.
REQ-014 SHALL have port: done  output  1  one-cycle pulse in DONE.
REQ-015 SHALL have port: product  output  2*WIDTH  unsigned result, held until the next accepted start.

Function
REQ-016 SHALL implement states IDLE, CALC and DONE.
REQ-017 SHALL go from IDLE to CALC on start=1; it SHALL load HI=0, LO=mplier, M=mcand and CNT=0.
REQ-018 SHALL use the adder once per CALC cycle: add_a=HI; add_b=M if LO[0]=1, otherwise 0.
REQ-019 SHALL, on each CALC edge, load {HI,LO} <= {add_cout, add_sum, LO[WIDTH-1:1]} and increment CNT.
REQ-020 SHALL go from CALC to DONE on the edge where CNT reaches WIDTH-1 (WIDTH iterations, no early termination).
REQ-021 SHALL have fixed latency: done is high during the (WIDTH+1)-th cycle after the start-accept edge (cycle 33 for WIDTH=32).
REQ-022 SHALL drive product = {HI,LO}; the value is valid from the DONE cycle until the next accepted start.
REQ-023 SHALL go from DONE to CALC on start=1, with operands reloaded (back-to-back operation, no idle bubble); otherwise it SHALL go to IDLE.
REQ-024 SHALL ignore start while in CALC: no operand capture and no restart.
REQ-025 SHALL, on abort=1 in CALC, go to IDLE next edge with done=0 and product cleared to 0; abort is ignored in IDLE and DONE.
REQ-026 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-027 SHALL present add_a, add_b = 0 outside CALC.
REQ-028 SHALL treat a CNT wrap as impossible; CNT width is clog2(WIDTH).
REQ-029 SHALL treat all arithmetic as unsigned, modulo 2^(2*WIDTH); the result never overflows.

Reset
REQ-030 SHALL, on rst=1, immediately (asynchronously) clear state to IDLE and clear HI, LO, M, CNT to 0.
REQ-031 SHALL hold busy=0, done=0, product=0, add_a=0, add_b=0 and add_cin=0 while rst=1.
REQ-032 SHALL discard any operation in progress on reset; after deassertion it waits in IDLE for start.

Structure
REQ-033 SHALL place the state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) in the shared ALU package.
REQ-034 SHALL place the default WIDTH constant in the shared ALU package.
REQ-035 SHALL contain no adder internally; the 32-bit carry-lookahead adder is instantiated beside it by the parent and wired through the add_* ports.
REQ-036 SHALL include one natural sub-module, seq_mult32_cnt, the iteration counter with clear, enable and terminal-count outputs.

Verification
REQ-037 SHALL cover: mcand=3, mplier=5, start 1 cycle -> busy for 32 cycles; done in cycle 33; product=64'h0000_0000_0000_000F.
REQ-038 SHALL cover: mcand=mplier=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; add_cout=1 observed during CALC.
REQ-039 SHALL cover: start re-pulsed with new operands in CALC cycle 10 -> ignored; first result 7*9=63 completes at cycle 33.
REQ-040 SHALL cover: start held high in DONE with 2*4 -> next cycle busy=1; second done 32 cycles later; product=8.
REQ-041 SHALL cover: rst pulsed asynchronously mid-CALC -> all outputs 0 immediately; IDLE after release; later 6*7=42 correct.
REQ-042 SHALL cover: abort and start asserted together in CALC cycle 5 -> IDLE next edge, done never pulses, product=0.
